div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 13 +
 rtl/div_step.sv | 24 ++
 rtl/div_ctrl.sv | 175 +++++++++++++++++
 tb/tb_div_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the multi-cycle restoring divider.
package div_ctrl_pkg;

    localparam int DIV_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shl;
    logic [WIDTH+1:0] diff;
    logic             unused_diff_bit;

    assign shl  = {rem_i, bit_i};
    // Two guard bits: the shifted remainder can reach 2^(WIDTH+1)-1, so the top bit is the borrow.
    assign diff = {1'b0, shl} - {2'b00, dvs_i};
    assign q_o  = ~diff[WIDTH+1];
    assign rem_o = q_o ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
    // Remainder stays below the divisor, so this bit is always zero once q_o is set.
    assign unused_diff_bit = diff[WIDTH];

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider, STEPS quotient bits per clock, MIPS-style hi/lo results.
// Define DIV_SIGNED_EN to honour the sign port; otherwise every division is unsigned.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF,
    parameter int STEPS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITERS = WIDTH / STEPS;
    localparam int CW    = $clog2(ITERS + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    logic             accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign accept = (state_q == IDLE) && start;

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic a_neg, b_neg;

    assign a_neg = sign & a[WIDTH-1];
    assign b_neg = sign & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

    // Most-negative / -1 falls out naturally: magnitude quotient 2^(W-1) negates to itself.
    assign q_fix = qneg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
    assign r_fix = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (accept) begin
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    logic unused_sign;

    assign unused_sign = sign;
    assign a_mag = a;
    assign b_mag = b;
    assign q_fix = dvd_q;
    assign r_fix = rem_q;
`endif

    // Step chain: the dividend register doubles as the quotient as bits shift in at the bottom.
    logic [STEPS:0][WIDTH-1:0] rem_c;
    logic [STEPS:0][WIDTH-1:0] dvd_c;
    logic [STEPS-1:0]          q_bit;

    assign rem_c[0] = rem_q;
    assign dvd_c[0] = dvd_q;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (rem_c[i]),
            .bit_i (dvd_c[i][WIDTH-1]),
            .dvs_i (dvs_q),
            .rem_o (rem_c[i+1]),
            .q_o   (q_bit[i])
        );
        assign dvd_c[i+1] = {dvd_c[i][WIDTH-2:0], q_bit[i]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    cnt_d   = CW'(ITERS);
                    state_d = (b == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                rem_d = rem_c[STEPS];
                dvd_d = dvd_c[STEPS];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = r_fix;
                lo_d    = q_fix;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ZERO: begin
                done_d  = 1'b1;
                div0_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: arithmetic reference model compared every cycle plus directed literals.
module tb_div_ctrl;

    localparam int W   = 32;
    localparam int S   = 1;
    localparam int LAT = W / S + 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sign  = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    div_ctrl #(.WIDTH(W), .STEPS(S)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Plain arithmetic reference for quotient/remainder.
    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        q = '0;
        r = '0;
        if (y != '0) begin
            q = x / y;
            r = x % y;
`ifdef DIV_SIGNED_EN
            if (s) begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    q = x;
                    r = '0;
                end else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                end
            end
`endif
        end
    endfunction

    // Cycle model: an accepted request makes the block busy for a fixed number of edges.
    logic         e_busy = 1'b0, e_done = 1'b0, e_div0 = 1'b0;
    logic [W-1:0] e_hi = '0, e_lo = '0, m_q = '0, m_r = '0;
    int           m_left = 0;
    bit           m_zero = 1'b0;

    always @(posedge clock) begin
        e_done = 1'b0;
        e_div0 = 1'b0;
        if (reset) begin
            m_left = 0;
            e_busy = 1'b0;
            e_hi   = '0;
            e_lo   = '0;
        end else if (m_left == 0) begin
            if (start) begin
                ref_div(a, b, sign, m_q, m_r);
                m_zero = (b == '0);
                m_left = m_zero ? 1 : LAT - 1;
                e_busy = 1'b1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                e_busy = 1'b0;
                e_done = 1'b1;
                e_div0 = m_zero;
                if (!m_zero) begin
                    e_hi = m_r;
                    e_lo = m_q;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_busy", busy, e_busy);
            chk("m_done", done, e_done);
            chk("m_div0", div0, e_div0);
            chk("m_hi",   hi,   e_hi);
            chk("m_lo",   lo,   e_lo);
        end
    end

    // Issue one request from idle and check result, latency and busy duration against literals.
    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      input logic [W-1:0] xq, input logic [W-1:0] xr, input logic xz, input string nm);
        int n;
        int nb;
        @(posedge clock); #1;
        start = 1'b1; a = x; b = y; sign = s;
        @(posedge clock); #1;
        start = 1'b0; a = $urandom; b = $urandom; sign = 1'($urandom);
        nb = 0;
        for (n = 1; n <= LAT + 5; n++) begin
            @(negedge clock);
            if (done) break;
            if (busy) nb++;
        end
        chk({nm, "_lat"},  n,  xz ? 2 : LAT);
        chk({nm, "_busy"}, nb, xz ? 1 : LAT - 1);
        chk({nm, "_lo"},   lo, xq);
        chk({nm, "_hi"},   hi, xr);
        chk({nm, "_div0"}, div0, xz);
    endtask

    task automatic wait_done(input string nm);
        int n;
        for (n = 0; n < LAT + 5; n++) begin
            @(negedge clock);
            if (done) break;
        end
        if (n == LAT + 5) chk({nm, "_timeout"}, 1, 0);
    endtask

    initial begin
        int nd;
        int k;
        @(posedge clock); #1;
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi",   hi,   0);
        chk("rst_lo",   lo,   0);
        @(posedge clock); #1;
        reset = 1'b0;

        op(100, 7, 1'b0, 14, 2, 1'b0, "u100_7");
        op(5, 0, 1'b0, 14, 2, 1'b1, "div0");
`ifdef DIV_SIGNED_EN
        op(32'hFFFF_FFF9, 2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "s_m7_2");
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b0, "s_ovf");
        op(32'hFFFF_FF9C, 7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "s_m100_7");
        op(100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 2, 1'b0, "s_100_m7");
`else
        op(32'hFFFF_FFFF, 2, 1'b1, 32'h7FFF_FFFF, 1, 1'b0, "u_ignsign");
`endif
        op(32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, "u_max_1");
        op(3, 10, 1'b0, 0, 3, 1'b0, "u_small");
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 0, 1'b0, "u_eq");

        // A start pulsed mid-run must not disturb the running division.
        @(posedge clock); #1;
        start = 1'b1; a = 1000; b = 9; sign = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1 start = 1'b1; a = 7; b = 1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done("busy_start");
        chk("busy_start_lo", lo, 111);
        chk("busy_start_hi", hi, 1);

        // Back-to-back: start held high is taken again in the done cycle.
        @(posedge clock); #1;
        start = 1'b1; a = 1000; b = 9;
        wait_done("b2b_first");
        @(posedge clock); #1;
        start = 1'b0;
        for (k = 1; k <= LAT + 5; k++) begin
            @(negedge clock);
            if (done) break;
        end
        chk("b2b_gap", k, LAT);

        // Reset at edge 10 of a run aborts it with no done pulse.
        @(posedge clock); #1;
        start = 1'b1; a = 100; b = 7; sign = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) nd++;
        end
        chk("abort_nodone", nd, 0);

        // Randomized traffic with stray starts while busy.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x, y;
            case ($urandom_range(0, 4))
                0: x = 32'h8000_0000;
                1: x = $urandom_range(0, 300);
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: y = '0;
                1: y = 32'hFFFF_FFFF;
                2: y = $urandom_range(1, 20);
                default: y = $urandom >> $urandom_range(0, 31);
            endcase
            @(posedge clock); #1;
            start = 1'b1; a = x; b = y; sign = 1'($urandom);
            @(posedge clock); #1;
            start = 1'b0;
            for (k = 0; k < LAT + 5; k++) begin
                @(negedge clock);
                if (done) break;
                start = ($urandom_range(0, 9) == 0);
                a = $urandom;
                b = $urandom;
            end
            start = 1'b0;
            if (k == LAT + 5) chk("rand_timeout", 1, 0);
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
